// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: shift-add multiply or restoring divide,
// one bit per cycle, with a fixed latency for every op and operand.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_accept;

  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_mb;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_result;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_sign;
  logic               r_done;

  // Operand sign handling, evaluated during PREP from the latched operands
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_sa;
  logic             w_sb;
  logic             w_sign;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;

  assign w_a_signed = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
  assign w_b_signed = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
  assign w_sa       = w_a_signed & r_a[WIDTH-1];
  assign w_sb       = w_b_signed & r_b[WIDTH-1];
  assign w_ma       = w_sa ? (~r_a + 1'b1) : r_a;
  assign w_mb       = w_sb ? (~r_b + 1'b1) : r_b;
  assign w_sign     = (r_op == 3'b110) ? w_sa : (w_sa ^ w_sb);

  // Multiply step: add the multiplicand into the upper half, then shift right
  logic [WIDTH:0] w_add;
  assign w_add = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, ({WIDTH{r_prod[0]}} & r_mb)};

  // Divide step: the WIDTH+1-bit partial remainder is the shifted remainder
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mb});
  assign w_diff  = w_shift[WIDTH-1:0] - r_mb;

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_fix;
  logic               w_b_zero;

  assign w_prod_fix = r_sign ? (~r_prod + 1'b1) : r_prod;
  assign w_quo_fix  = r_sign ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix  = r_sign ? (~r_rem + 1'b1) : r_rem;
  assign w_b_zero   = (r_b == '0);

  // Signed overflow (MIN / -1) falls out of the magnitude path naturally
  always_comb begin
    w_fix = '0;
    case (r_op)
      3'b000:                 w_fix = w_prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fix = w_b_zero ? '1 : w_quo_fix;
      default:                w_fix = w_b_zero ? r_a : w_rem_fix;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // the done pulse cycle is still part of the operation, so no accept there
        if (start && !kill && !r_done) begin
          w_accept     = 1'b1;
          w_state_next = S_PREP;
        end
      end
      S_PREP:  w_state_next = S_CALC;
      S_CALC:  if (r_cnt == LAST) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (kill) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mb     <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE) && !kill;
      if (w_accept) begin
        r_op <= op;
        r_a  <= src_a;
        r_b  <= src_b;
      end
      case (r_state)
        S_PREP: begin
          r_mb   <= w_mb;
          r_sign <= w_sign;
          r_cnt  <= '0;
          r_prod <= {{WIDTH{1'b0}}, w_ma};
          r_rem  <= '0;
          r_quo  <= w_ma;
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[2]) begin
            r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
          end else begin
            r_prod <= {w_add, r_prod[WIDTH-1:1]};
          end
        end
        S_FIX: if (!kill) r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE) || r_done;
  assign done   = r_done;
  assign result = r_result;

endmodule
